// File: rtl/sw_debounce_port.sv
// sw_debounce_port: conditions raw slide-switch inputs for the CPU input port.
// Two-flop synchroniser, per-bit debounce counter, registered stable level,
// one-cycle change strobe and a saturating change counter.
//
// Optional feature macro: SW_EVENT_LATCH_EN
//   defined   -> sticky event bit on port_value[31], set by sw_changed,
//                cleared by rd_ack (set wins when both coincide)
//   undefined -> port_value[31] tied 0, rd_ack ignored
//
// Ports:
//   clk          system clock, all state on rising edge
//   reset        synchronous active-low reset
//   sw_raw       asynchronous switch levels from the board pins
//   rd_ack       CPU read acknowledge (event clear)
//   sw_stable    debounced switch levels
//   sw_changed   one-cycle pulse when any sw_stable bit changes
//   change_count saturating count of sw_changed pulses
//   port_value   CPU-visible word {evt, zeros, sw_stable}
//
// Parameters: NUM_SW (1..16), DB_CYCLES (>= 2), CNT_W (2^CNT_W > DB_CYCLES).

module sw_debounce_port #(
    parameter int unsigned NUM_SW    = 5,
    parameter int unsigned DB_CYCLES = 500000,
    parameter int unsigned CNT_W     = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_SW-1:0] sw_raw,
    input  logic              rd_ack,
    output logic [NUM_SW-1:0] sw_stable,
    output logic              sw_changed,
    output logic [7:0]        change_count,
    output logic [31:0]       port_value
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DB_CYCLES - 1);
    localparam logic [7:0]       COUNT_MAX = 8'hFF;

    logic [NUM_SW-1:0] s1_q;
    logic [NUM_SW-1:0] s2_q;
    logic [CNT_W-1:0]  cnt_q [NUM_SW];
    logic [CNT_W-1:0]  cnt_d [NUM_SW];
    logic [NUM_SW-1:0] stable_q;
    logic [NUM_SW-1:0] stable_d;
    logic              changed_q;
    logic              changed_d;
    logic [7:0]        count_q;
    logic [7:0]        count_d;
    logic [31:0]       port_q;
    logic [31:0]       port_d;
    logic              evt_d;

    // Per-bit debounce: count consecutive cycles that s2 disagrees with the
    // stable level; accept the new level on the DB_CYCLES-th such cycle.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(NUM_SW); i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Strobe and counter are computed from the same edge that updates
    // sw_stable, so all three become visible together.
    always_comb begin
        changed_d = |(stable_d ^ stable_q);
        count_d   = count_q;
        if (changed_d && (count_q != COUNT_MAX)) begin
            count_d = count_q + 8'd1;
        end
    end

`ifdef SW_EVENT_LATCH_EN
    logic evt_q;

    // Sticky event: set by the visible strobe, cleared by rd_ack; set wins.
    always_comb begin
        evt_d = changed_q | (evt_q & ~rd_ack);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            evt_q <= 1'b0;
        end else begin
            evt_q <= evt_d;
        end
    end
`else
    logic unused_rd_ack;

    assign unused_rd_ack = rd_ack;

    always_comb begin
        evt_d = 1'b0;
    end
`endif

    // CPU word assembled from next-state values so it tracks the registers.
    always_comb begin
        port_d                 = '0;
        port_d[NUM_SW-1:0]     = stable_d;
        port_d[31]             = evt_d;
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            stable_q  <= '0;
            changed_q <= 1'b0;
            count_q   <= '0;
            port_q    <= '0;
            for (int i = 0; i < int'(NUM_SW); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= sw_raw;
            s2_q      <= s1_q;
            stable_q  <= stable_d;
            changed_q <= changed_d;
            count_q   <= count_d;
            port_q    <= port_d;
            for (int i = 0; i < int'(NUM_SW); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_stable    = stable_q;
    assign sw_changed   = changed_q;
    assign change_count = count_q;
    assign port_value   = port_q;

endmodule

// File: tb/tb_sw_debounce_port.sv
// Testbench for sw_debounce_port (NUM_SW=5, DB_CYCLES=4, CNT_W=3).
// A reference model predicts every stable-level change from a sliding window
// of synchronised samples; predictions go into a queue that a negedge monitor
// pops whenever the DUT strobes sw_changed.

module tb_sw_debounce_port;

    localparam int NSW = 5;
    localparam int DB  = 4;

    typedef struct {
        int         cyc;
        logic [4:0] stable;
        logic [7:0] count;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [4:0]  sw_raw;
    logic        rd_ack;
    logic [4:0]  sw_stable;
    logic        sw_changed;
    logic [7:0]  change_count;
    logic [31:0] port_value;

    sw_debounce_port #(
        .NUM_SW   (NSW),
        .DB_CYCLES(DB),
        .CNT_W    (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw_raw      (sw_raw),
        .rd_ack      (rd_ack),
        .sw_stable   (sw_stable),
        .sw_changed  (sw_changed),
        .change_count(change_count),
        .port_value  (port_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 0;

    // Reference model state
    logic [4:0] m_s1 = '0, m_s2 = '0, m_stable = '0;
    logic [7:0] m_count = '0;
    logic       m_pulse = 1'b0, m_evt = 1'b0;
    logic [4:0] hist[$];
    exp_t       q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model of one clock edge: a bit takes the new level when the last DB
    // synchronised samples all oppose the current stable level.
    task automatic model_edge(input logic [4:0] raw, input logic rst_n, input logic ack);
        logic [4:0] nxt;
        bit         all_opp;
        exp_t       e;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_count = '0;
            m_pulse = 1'b0; m_evt = 1'b0;
            hist.delete();
        end else begin
            m_evt = m_pulse | (m_evt & ~ack);
            hist.push_back(m_s2);
            while (hist.size() > DB) e.cyc = int'(hist.pop_front());
            nxt = m_stable;
            if (hist.size() == DB) begin
                for (int b = 0; b < NSW; b++) begin
                    all_opp = 1;
                    foreach (hist[k]) if (hist[k][b] == m_stable[b]) all_opp = 0;
                    if (all_opp) nxt[b] = ~m_stable[b];
                end
            end
            m_pulse = (nxt != m_stable);
            if (m_pulse) begin
                if (m_count != 8'hFF) m_count = m_count + 8'd1;
                e.cyc = cyc; e.stable = nxt; e.count = m_count;
                q.push_back(e);
            end
            m_stable = nxt;
            m_s2 = m_s1;
            m_s1 = raw;
        end
    endtask

    task automatic step(input logic [4:0] raw, input logic rst_n, input logic ack);
        @(negedge clk);
        sw_raw = raw; reset = rst_n; rd_ack = ack;
        @(posedge clk);
        cyc++;
        model_edge(raw, rst_n, ack);
        mon_en = 1;
    endtask

    // Drives raw until a strobe is seen; lat = edges since the edge before the change.
    task automatic run_until_change(input logic [4:0] raw, input logic ack, output int lat);
        int c0;
        c0  = cyc;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            step(raw, 1'b1, ack);
            #1;
            if (sw_changed) begin
                lat = cyc - c0;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++; n_fail++;
            $display("FAIL change_timeout: no sw_changed within 20 cycles for raw %h", raw);
        end
    endtask

    // Scoreboard monitor
    logic [31:0] mon_pv;
    exp_t        mon_e;
    always @(negedge clk) begin
        if (mon_en) begin
            mon_pv = 32'(m_stable);
`ifdef SW_EVENT_LATCH_EN
            mon_pv[31] = m_evt;
`endif
            chk("port_value", port_value, mon_pv);
            if (sw_changed) begin
                if (q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_pulse: got sw_changed=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_e = q.pop_front();
                    chk("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
                    chk("pulse_stable", 32'(sw_stable), 32'(mon_e.stable));
                    chk("pulse_count", 32'(change_count), 32'(mon_e.count));
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                mon_e = q.pop_front();
                n_checks++; n_fail++;
                $display("FAIL missing_pulse: got sw_changed=0 expected 1 at cycle %0d", mon_e.cyc);
            end
        end
    end

    int         lat;
    logic [7:0] cnt_before;
    logic [4:0] rnd_raw;

    initial begin
        sw_raw = '0; reset = 1'b0; rd_ack = 1'b0;

        // Reset held with all switches high
        repeat (3) step(5'h1F, 1'b0, 1'b0);
        #1;
        chk("rst_stable", 32'(sw_stable), 32'h0);
        chk("rst_changed", 32'(sw_changed), 32'h0);
        chk("rst_count", 32'(change_count), 32'h0);
        chk("rst_port", port_value, 32'h0);
        run_until_change(5'h1F, 1'b0, lat);
        chk("rst_release_lat", 32'(lat), 32'd6);
        chk("rst_release_stable", 32'(sw_stable), 32'h1F);
        chk("rst_release_count", 32'(change_count), 32'd1);

        // Settle to zero
        run_until_change(5'h00, 1'b0, lat);
        repeat (4) step(5'h00, 1'b1, 1'b0);

        // Glitch on bit0 shorter than the debounce window
        cnt_before = change_count;
        repeat (3) step(5'h01, 1'b1, 1'b0);
        repeat (10) step(5'h00, 1'b1, 1'b0);
        #1;
        chk("glitch_stable", 32'(sw_stable), 32'h0);
        chk("glitch_count", 32'(change_count), 32'(cnt_before));

        // Clean step 00 -> 05
        run_until_change(5'h05, 1'b0, lat);
        chk("step_lat", 32'(lat), 32'd6);
        chk("step_port", port_value & 32'h7FFF_FFFF, 32'h0000_0005);
        repeat (4) step(5'h05, 1'b1, 1'b0);

`ifdef SW_EVENT_LATCH_EN
        // Sticky event: set after change, cleared by rd_ack; coincident ack loses
        #1;
        chk("evt_set", 32'(port_value[31]), 32'd1);
        step(5'h05, 1'b1, 1'b1);
        #1;
        chk("evt_clear", 32'(port_value[31]), 32'd0);
        run_until_change(5'h00, 1'b0, lat);
        step(5'h00, 1'b1, 1'b1);
        #1;
        chk("evt_coincident", 32'(port_value[31]), 32'd1);
        step(5'h00, 1'b1, 1'b1);
        #1;
        chk("evt_clear2", 32'(port_value[31]), 32'd0);
`else
        run_until_change(5'h00, 1'b0, lat);
`endif
        repeat (4) step(5'h00, 1'b1, 1'b0);

        // Bounce on bit2 then settle high
        step(5'h04, 1'b1, 1'b0);
        step(5'h00, 1'b1, 1'b0);
        step(5'h04, 1'b1, 1'b0);
        step(5'h00, 1'b1, 1'b0);
        cnt_before = change_count;
        run_until_change(5'h04, 1'b0, lat);
        chk("bounce_lat", 32'(lat), 32'd6);
        chk("bounce_stable", 32'(sw_stable), 32'h04);
        chk("bounce_count", 32'(change_count), 32'(cnt_before + 8'd1));

        // Reset mid-debounce discards the pending count
        repeat (4) step(5'h1B, 1'b1, 1'b0);
        step(5'h1B, 1'b0, 1'b0);
        run_until_change(5'h1B, 1'b0, lat);
        chk("midrst_lat", 32'(lat), 32'd6);
        chk("midrst_stable", 32'(sw_stable), 32'h1B);

        // Saturation: 300 qualified toggles of bit4
        for (int t = 0; t < 300; t++) begin
            repeat (7) step((t % 2 == 0) ? 5'h0B : 5'h1B, 1'b1, 1'b0);
        end
        #1;
        chk("sat_count", 32'(change_count), 32'd255);

        // Random bouncing switches and random acks
        rnd_raw = 5'h1B;
        for (int t = 0; t < 1500; t++) begin
            for (int b = 0; b < NSW; b++)
                if ($urandom_range(0, 5) == 0) rnd_raw[b] = ~rnd_raw[b];
            step(rnd_raw, 1'b1, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
        end

        // Drain and confirm every predicted change was seen
        repeat (12) step(rnd_raw, 1'b1, 1'b0);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("final_stable", 32'(sw_stable), 32'(rnd_raw));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sw_debounce_port.md
Name: sw_debounce_port

Overview:
- Conditions raw slide-switch inputs (SW0..SW9 groups) before they reach the CPU input-port logic: 2-flop synchroniser, per-bit debounce counter, registered stable value.
- One instance per 5-switch group; its port_value output feeds the in_port0/in_port1 words read by sc_computer_main.
- Also produces a one-cycle change strobe and a running change counter for diagnostics.

Parameters:
- NUM_SW, 5, number of switch bits handled (1..16).
- DB_CYCLES, 500000, consecutive stable cycles required before a new level is accepted (10 ms at 50 MHz); must be >= 2.
- CNT_W, 20, width of each per-bit debounce counter; must satisfy 2^CNT_W > DB_CYCLES.

Ports:
- clk, input, 1, system clock; all state on rising edge.
- reset, input, 1, synchronous active-low reset.
- sw_raw, input, NUM_SW, asynchronous switch levels from the board pins.
- rd_ack, input, 1, CPU read acknowledge; used only when SW_EVENT_LATCH_EN is defined, ignored otherwise.
- sw_stable, output, NUM_SW, debounced switch levels.
- sw_changed, output, 1, one-cycle pulse when any bit of sw_stable changes.
- change_count, output, 8, saturating count of sw_changed pulses.
- port_value, output, 32, CPU-visible word: {sticky bit or 0 at [31], zeros, sw_stable at [NUM_SW-1:0]}.

Behaviour:
- Reset: when reset==0 at a clk edge, all registers clear. sync flops = 0, counters = 0, sw_stable = 0, sw_changed = 0, change_count = 0, port_value = 0.
- Synchroniser: s1 <= sw_raw; s2 <= s1. Only s2 is used downstream.
- Per bit i, each cycle:
  - If s2[i] == sw_stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == DB_CYCLES-1: sw_stable[i] <= s2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- Latency: a clean input step appears on sw_stable exactly 2 + DB_CYCLES clk edges after the sw_raw transition edge.
- Glitch rejection:
  - Any return of s2[i] to sw_stable[i] before the count completes zeroes cnt[i].
  - A glitch shorter than DB_CYCLES cycles never reaches sw_stable.
- Bits are independent. Simultaneous completions on several bits update in the same cycle and produce a single sw_changed pulse.
- sw_changed is registered: it is high for exactly the one cycle in which the new sw_stable value is first visible, and low otherwise.
- change_count increments on each sw_changed pulse and saturates at 255 (no wrap).
- port_value is fully registered. Bits [30:NUM_SW] are always 0. Bit [31] is 0 unless the optional feature is enabled.
- Reset asserted mid-debounce: the pending count is discarded. After release, a level held high re-qualifies from zero (2 + DB_CYCLES cycles).
- Inputs that are high at reset release are treated as changes: the first sw_changed pulse after reset fires once they qualify.

Optional Feature:
- Macro: SW_EVENT_LATCH_EN.
- Defined:
  - Sticky register evt sets on sw_changed; port_value[31] = evt.
  - rd_ack==1 clears evt on the next edge.
  - If sw_changed and rd_ack coincide, set wins (evt stays 1).
  - Reset clears evt.
- Undefined: no evt register; port_value[31] is tied 0; rd_ack is unused.

Test Plan (DB_CYCLES=4, CNT_W=3, NUM_SW=5):
- Reset: hold reset=0 for 3 cycles with sw_raw=5'h1F -> sw_stable=0, sw_changed=0, change_count=0, port_value=0. Release -> sw_stable=5'h1F at edge 6 after release, one sw_changed pulse, change_count=1.
- Clean step: sw_raw 5'h00->5'h05 held -> sw_stable=5'h05 exactly 6 edges later; port_value=32'h00000005; one sw_changed pulse.
- Glitch: bit0 pulses high for 3 cycles then low -> sw_stable unchanged, no sw_changed, change_count unchanged.
- Bounce then settle:
  - Stimulus: bit2 toggles 1,0,1,0,1 each cycle, then holds 1.
  - Required: sw_stable[2] rises 6 edges after the final rise; exactly one pulse.
- Saturation: 300 qualified toggles -> change_count stays 255.
- With SW_EVENT_LATCH_EN:
  - Change -> port_value[31]=1; rd_ack pulse -> 0 next cycle.
  - rd_ack coincident with sw_changed -> port_value[31] stays 1.
  - Without the macro: port_value[31]=0 throughout.
